// File: rtl/led_pulse.sv
`default_nettype none
// ============================================================================
// Module      : led_pulse
// Description : Turns a single-cycle start request into a burst of N visible
//               LED blinks (ON_TICKS high, OFF_TICKS low per blink), with a
//               busy flag and a one-cycle done pulse at burst end.
//               Optional macro LED_PULSE_RETRIGGER_EN: a start while busy
//               restarts (N > 0) or aborts (N = 0) the running burst.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pulse #(
    parameter int unsigned ON_TICKS  = 100000,
    parameter int unsigned OFF_TICKS = 100000,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             led
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [31:0]      C_ON_LAST  = 32'(ON_TICKS - 1);
    localparam logic [31:0]      C_OFF_LAST = 32'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_t             state_q, state_d;
    logic [31:0]        timer_q, timer_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State register; outputs are flopped so nothing combinational reaches the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= 32'd0;
            remaining_q <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, timer and blink bookkeeping; outputs derive from the next state.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        remaining_d = count;
                        timer_d     = 32'd0;
                        state_d     = ON;
                    end else begin
                        // Empty request completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            ON: begin
                if (timer_q == C_ON_LAST) begin
                    timer_d = 32'd0;
                    state_d = OFF;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            OFF: begin
                if (timer_q == C_OFF_LAST) begin
                    timer_d = 32'd0;
                    // Guarded decrement: the counter can never wrap below zero.
                    remaining_d = (remaining_q != '0) ? remaining_q - C_ONE : '0;
                    if (remaining_q <= C_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ON;
                    end
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                timer_d     = 32'd0;
                remaining_d = '0;
            end
        endcase

`ifdef LED_PULSE_RETRIGGER_EN
        // A request during a burst overrides it; the aborted burst gets no done.
        if (start && (state_q == ON || state_q == OFF)) begin
            timer_d = 32'd0;
            if (count != '0) begin
                remaining_d = count;
                state_d     = ON;
                done_d      = 1'b0;
            end else begin
                remaining_d = '0;
                state_d     = IDLE;
                done_d      = 1'b1;
            end
        end
`else
        // Requests arriving during a burst are simply dropped.
`endif

        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: doc/led_pulse.md
# led_pulse

Output-side counterpart to the push-button debouncer: it turns single-cycle event requests from the design into a burst of LED blinks that a person can see. It sits between control logic (for example, a debounced key handler) and the board LED pin. Each request selects a blink count. The block runs each blink as a long on-period and off-period with its own tick counter, and reports completion with a handshake.

## Interface
Parameters:
- ON_TICKS, 100000, clock cycles that `led` is high per blink; must be ≥ 1.
- OFF_TICKS, 100000, clock cycles that `led` is low after each blink; must be ≥ 1.
- CNT_W, 4, width of the blink-count request.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled every posedge.
- count  input  CNT_W  number of blinks; sampled together with `start`.
- busy  output  1  high while a blink burst is in progress.
- done  output  1  one-cycle pulse when a burst ends.
- led  output  1  LED drive; 1 = lit.

## Operation
- States: IDLE, ON, OFF. Timer is 32-bit. Remaining-blink register is CNT_W bits.
- Reset (`rst_n` low, asynchronous): state IDLE, timer 0, remaining 0, led 0, busy 0, done 0.
- Reset mid-burst aborts immediately: `led` drops with no clock edge, and no `done` is produced.
- IDLE, `start` high, count N > 0:
  - Latch remaining = N, timer = 0.
  - Go to ON.
- IDLE, `start` high, count 0:
  - Stay IDLE and pulse `done` the next cycle.
  - `led` and `busy` stay 0.
- IDLE, `start` low: hold; `done` deasserts after its one cycle.
- ON: `led` = 1. Timer counts up each cycle. When timer == ON_TICKS-1: timer ← 0, go to OFF.
- OFF: `led` = 0. Timer counts up each cycle. When timer == OFF_TICKS-1: timer ← 0, remaining ← remaining-1, then:
  - If remaining was 1: go to IDLE.
  - Otherwise: go to ON.
- `busy` = 1 in ON or OFF, else 0.
- `done` = 1 exactly in the first IDLE cycle after the final OFF period. It is also 1 in the cycle after a count-0 request.
- `start` while busy: ignored, unless the retrigger option below is compiled in.
- A `start` sampled in a cycle where `done` = 1 is accepted normally, since the state is IDLE. This allows back-to-back bursts with no gap.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Latency from the `start` edge to `led` rising: 1 cycle.
- Burst of N blinks: `busy` is high for exactly N·(ON_TICKS+OFF_TICKS) cycles.
- `led` pattern within a burst: high for ON_TICKS cycles, then low for OFF_TICKS cycles, repeated N times.
- `done` goes high in the cycle `busy` falls and lasts 1 cycle.
- Maximum N = 2^CNT_W − 1. The remaining-blink register never wraps, because the decrement happens only while remaining ≥ 1.

## Configuration
- Macro: LED_PULSE_RETRIGGER_EN.
- Defined: `start` with N > 0 in ON or OFF restarts the burst.
  - remaining = N, timer = 0, state ON (`led` = 1 next cycle).
  - No `done` is emitted for the aborted burst.
  - `start` with N = 0 while busy aborts to IDLE: `led` 0 and `done` 1 the next cycle.
- Not defined: `start` while busy has no effect.

## Test plan
Bench parameters: ON_TICKS=3, OFF_TICKS=2.
- Reset check: hold `rst_n` low, then release -> `led`, `busy` and `done` all 0, with no activity before `start`.
- Two-blink burst: `start` for 1 cycle with count=2 -> `led` reads 1,1,1,0,0,1,1,1,0,0 from the next cycle. `busy` stays high for 10 cycles. `done` is 1 on cycle 11 only.
- Zero count: `start` with count=0 -> `done` 1 the next cycle. `led` and `busy` stay 0.
- Back-to-back: assert `start` with count=1 again in the `done` cycle -> a second burst begins 1 cycle later with no idle gap. Each burst produces exactly one `done`.
- Asynchronous reset during the ON phase of a count=3 burst -> `led` and `busy` drop 0 without a clock edge. No `done` follows. A fresh `start` works normally.
- Retrigger: `start` count=3, then `start` count=1 at cycle 4.
  - Without LED_PULSE_RETRIGGER_EN: 3 blinks total, `done` after 15 cycles.
  - With LED_PULSE_RETRIGGER_EN: 1 blink restarts at cycle 5, and `done` arrives 5 cycles later.
